// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared state codes, frame layout and checksum for the DHT poll scheduler
// DHT_WATCHDOG_RST_EN adds the reader-reset hold state.
package dht_pkg;

    localparam int FRAME_W = 40;
    localparam int RH_INT  = 39;
    localparam int RH_DEC  = 31;
    localparam int T_INT   = 23;
    localparam int T_DEC   = 15;
    localparam int CSUM    = 7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_GAP = 3'd1;
    localparam state_t ST_START    = 3'd2;
    localparam state_t ST_BUSY     = 3'd3;
    localparam state_t ST_CHECK    = 3'd4;
    localparam state_t ST_PUBLISH  = 3'd5;
    localparam state_t ST_RETRY    = 3'd6;
`ifdef DHT_WATCHDOG_RST_EN
    localparam state_t ST_WDOG     = 3'd7;
`endif

    typedef struct packed {
        logic [7:0] rh_int;
        logic [7:0] rh_dec;
        logic [7:0] t_int;
        logic [7:0] t_dec;
        logic [7:0] csum;
    } frame_t;

    // Sensor checksum: low byte of the sum of the four data bytes.
    function automatic logic csum_ok(input logic [FRAME_W-1:0] f);
        logic [7:0] sum;
        sum = f[RH_INT -: 8] + f[RH_DEC -: 8] + f[T_INT -: 8] + f[T_DEC -: 8];
        return sum == f[CSUM -: 8];
    endfunction

endpackage

// File: rtl/dht_poll_scheduler_if.sv
// rtl/dht_poll_scheduler_if.sv - reader and sample-consumer handshake signals of the DHT poll scheduler
interface dht_poll_scheduler_if;
    import dht_pkg::*;

    logic               dht_start;
    logic [FRAME_W-1:0] dht_data;
    logic               dht_data_ready;
    logic               dht_error;
    logic [31:0]        sample_data;
    logic               sample_valid;
    logic               sample_ack;
    logic               overrun;

    modport master (
        output dht_start, sample_data, sample_valid, overrun,
        input  dht_data, dht_data_ready, dht_error, sample_ack
    );

    modport slave (
        input  dht_start, sample_data, sample_valid, overrun,
        output dht_data, dht_data_ready, dht_error, sample_ack
    );

endinterface

// File: rtl/dht_interval_timer.sv
// rtl/dht_interval_timer.sv - saturating inter-start gap counter and auto-poll period tick generator
module dht_interval_timer #(
    parameter int unsigned MIN_GAP_CYC = 200_000_000,
    parameter int          PERIOD_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                gap_clear,
    input  logic                tick_en,
    input  logic [PERIOD_W-1:0] period,
    output logic                gap_ok,
    output logic                tick
);
    localparam int GAP_W = $clog2(MIN_GAP_CYC + 1);

    logic [GAP_W-1:0]    gap_cnt;
    logic [PERIOD_W-1:0] per_cnt;
    logic                per_run;

    assign gap_ok  = (gap_cnt == GAP_W'(MIN_GAP_CYC));
    assign per_run = tick_en && (period != '0);
    assign tick    = per_run && (per_cnt == period - PERIOD_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            per_cnt <= '0;
        end else begin
            if (gap_clear)
                gap_cnt <= '0;
            else if (!gap_ok)
                gap_cnt <= gap_cnt + GAP_W'(1);

            if (!per_run || tick)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/dht_poll_scheduler.sv
// rtl/dht_poll_scheduler.sv - DHT read sequencer: start pacing, checksum, retries, sample handshake
// DHT_WATCHDOG_RST_EN adds dht_rst_n, pulsed low for 4 cycles after a read timeout.
module dht_poll_scheduler
    import dht_pkg::*;
#(
    parameter int unsigned MIN_GAP_CYC = 200_000_000,
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int          PERIOD_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dht_poll_scheduler_if.master bus,
    input  logic                 enable,
    input  logic                 req,
    input  logic [PERIOD_W-1:0]  period_cfg,
    output logic                 busy,
    output logic                 fail,
    output logic [1:0]           retry_cnt
`ifdef DHT_WATCHDOG_RST_EN
    ,
    output logic                 dht_rst_n
`endif
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t          state;
    logic            pending;
    logic            new_read;
    logic            gap_ok;
    logic            tick;
    logic            can_retry;
    logic            timeout;
    frame_t          frame;
    logic [TO_W-1:0] to_cnt;
`ifdef DHT_WATCHDOG_RST_EN
    logic [1:0]      wd_cnt;
`endif

    dht_interval_timer #(
        .MIN_GAP_CYC (MIN_GAP_CYC),
        .PERIOD_W    (PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .gap_clear (state == ST_START),
        .tick_en   (enable),
        .period    (period_cfg),
        .gap_ok    (gap_ok),
        .tick      (tick)
    );

    assign can_retry     = 32'(retry_cnt) < MAX_RETRIES;
    assign timeout       = (to_cnt == TO_W'(TIMEOUT_CYC));
    assign bus.dht_start = (state == ST_START);
    assign busy          = (state == ST_START) || (state == ST_BUSY) || (state == ST_CHECK);
    assign fail          = (state == ST_RETRY) && !can_retry;
`ifdef DHT_WATCHDOG_RST_EN
    assign dht_rst_n     = (state != ST_WDOG);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pending          <= 1'b0;
            new_read         <= 1'b0;
            frame            <= '0;
            to_cnt           <= '0;
            retry_cnt        <= '0;
            bus.sample_data  <= '0;
            bus.sample_valid <= 1'b0;
            bus.overrun      <= 1'b0;
`ifdef DHT_WATCHDOG_RST_EN
            wd_cnt           <= '0;
`endif
        end else begin
            // A request arriving during the start cycle must survive to give a follow-up read.
            if (req || tick)
                pending <= 1'b1;
            else if (state == ST_START)
                pending <= 1'b0;

            if (state == ST_PUBLISH)
                bus.sample_valid <= 1'b1;
            else if (bus.sample_ack)
                bus.sample_valid <= 1'b0;

            if (state == ST_PUBLISH && bus.sample_valid && !bus.sample_ack)
                bus.overrun <= 1'b1;
            else if (bus.sample_ack)
                bus.overrun <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pending && enable) begin
                        new_read <= 1'b1;
                        state    <= ST_WAIT_GAP;
                    end
                end
                // Retries ignore enable; only a fresh read is held back by it.
                ST_WAIT_GAP: begin
                    if (new_read && !enable)
                        state <= ST_IDLE;
                    else if (gap_ok)
                        state <= ST_START;
                end
                ST_START: begin
                    to_cnt   <= '0;
                    new_read <= 1'b0;
                    if (new_read)
                        retry_cnt <= '0;
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (bus.dht_error) begin
                        state <= ST_RETRY;
                    end else if (bus.dht_data_ready) begin
                        frame <= frame_t'(bus.dht_data);
                        state <= ST_CHECK;
                    end else if (timeout) begin
`ifdef DHT_WATCHDOG_RST_EN
                        wd_cnt <= '0;
                        state  <= ST_WDOG;
`else
                        state  <= ST_RETRY;
`endif
                    end
                end
                ST_CHECK: begin
                    state <= csum_ok(frame) ? ST_PUBLISH : ST_RETRY;
                end
                ST_PUBLISH: begin
                    bus.sample_data <= {frame.rh_int, frame.rh_dec, frame.t_int, frame.t_dec};
                    state           <= ST_IDLE;
                end
                ST_RETRY: begin
                    if (can_retry) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        state     <= ST_WAIT_GAP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`ifdef DHT_WATCHDOG_RST_EN
                ST_WDOG: begin
                    wd_cnt <= wd_cnt + 2'd1;
                    if (wd_cnt == 2'd3)
                        state <= ST_RETRY;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dht_poll_scheduler.md
Name: dht_poll_scheduler

Overview:
Sequences the DHT sensor reader (DTH block). Issues its one-cycle start pulses, enforces the sensor's minimum inter-read gap, and validates the 40-bit frame checksum. Retries failed reads with a timeout watchdog and publishes good samples to a consumer over a valid/ack handshake. Sits between the DTH reader and the register/bus layer that consumes humidity/temperature.

Parameters:
MIN_GAP_CYC, 200_000_000, minimum cycles between consecutive start pulses (2 s at 100 MHz)
TIMEOUT_CYC, 5_000_000, cycles allowed from start pulse to ready/error before declaring timeout (50 ms)
MAX_RETRIES, 3, retries after the first failed attempt before giving up
PERIOD_W, 32, width of the auto-poll period register

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
enable  in  1  permits new start pulses; 0 blocks starts
req  in  1  one-cycle on-demand read request
period_cfg  in  PERIOD_W  auto-poll period in cycles; 0 disables auto-poll
dht_start  out  1  one-cycle start pulse to DTH reader
dht_data  in  40  frame from reader: RH int, RH dec, T int, T dec, checksum (MSB first)
dht_data_ready  in  1  reader frame-complete strobe
dht_error  in  1  reader protocol-error strobe
sample_data  out  32  last good frame bits [39:8]
sample_valid  out  1  good sample pending; held until ack
sample_ack  in  1  consumer accepts sample
busy  out  1  read attempt in progress (START..CHECK)
fail  out  1  one-cycle pulse: all attempts failed
overrun  out  1  sticky: unacked sample overwritten; cleared by sample_ack
retry_cnt  out  2  retries used in current/last read

Behaviour:
- Reset: state IDLE. All outputs 0; pending=0; gap counter=0, so the first start waits the full MIN_GAP_CYC after reset (sensor power-up settle).
- Gap counter: counts up, saturating at MIN_GAP_CYC; cleared on every dht_start pulse.
- Period timer: runs while enable=1 and period_cfg!=0. On reaching period_cfg-1, sets pending and restarts. Held at 0 otherwise.
- Pending: set by req, or by a period tick while enable=1. A tick and req in the same cycle yield one read. Cleared on the start pulse. A req during busy sets pending again, giving exactly one follow-up read.
- States:
  - IDLE: if pending and enable, go to WAIT_GAP.
  - WAIT_GAP: when gap saturated, go to START.
  - START: dht_start=1 for exactly one cycle, clear gap/pending, load timeout counter, go to BUSY.
  - BUSY: on dht_data_ready, latch frame and go to CHECK. On dht_error or timeout counter reaching TIMEOUT_CYC, go to RETRY. If ready and error arrive in the same cycle, error wins.
  - CHECK (1 cycle): sum of bytes [39:32]+[31:24]+[23:16]+[15:8] mod 256 compared with [7:0]. Match goes to PUBLISH; mismatch goes to RETRY.
  - PUBLISH: sample_data<=frame[39:8], sample_valid<=1, retry_cnt kept, go to IDLE.
  - RETRY: if retry_cnt<MAX_RETRIES, increment and go to WAIT_GAP. The gap is still enforced, and enable is not rechecked for the retry. Otherwise pulse fail, go to IDLE.
- retry_cnt is cleared on the first start pulse of a new read (not on retries).
- Handshake: sample_valid falls the cycle after sample_ack=1. If PUBLISH coincides with sample_ack, the new sample wins: valid stays 1 and there is no overrun. If PUBLISH occurs with valid=1 and no ack, set overrun.
- enable falling mid-read: the in-flight attempt and its retries complete; no new read starts from IDLE. Pending persists until enable returns.
- Unexpected dht_data_ready/dht_error outside BUSY: ignored.
- Asynchronous reset mid-read: returns to reset values immediately; any partial frame is discarded.

Optional Feature:
- Macro DHT_WATCHDOG_RST_EN. When defined, adds output dht_rst_n (1 bit).
  - Normally 1.
  - On a BUSY timeout it is driven low for 4 cycles, then high, before the RETRY decision completes. This recovers a hung reader.
- Without the macro, the port is absent and a timeout is treated identically to dht_error.

Decomposition:
- Shared package dht_pkg:
  - state enum
  - frame byte-index constants (RH_INT=39, RH_DEC=31, T_INT=23, T_DEC=15, CSUM=7)
  - checksum function
  - FRAME_W=40
- One sub-module, dht_interval_timer: a saturating gap counter plus the period tick generator. It takes clear/enable/period inputs and produces gap_ok/tick outputs.

Test Plan:
(Bench overrides MIN_GAP_CYC=1000, TIMEOUT_CYC=500, MAX_RETRIES=2.)
- Reset then req at cycle 10 -> dht_start pulses once at cycle ≥1000 after reset. Reader returns 0x3A_00_19_00_53 -> sample_valid=1, sample_data=0x3A001900, retry_cnt=0.
- Bad checksum 0x3A_00_19_00_54 twice, then good frame -> three start pulses ≥1000 cycles apart, retry_cnt=2, sample_valid=1, no fail.
- Reader silent after every start -> three starts, each attempt times out at 500 cycles, fail pulses once, sample_valid stays 0. With DHT_WATCHDOG_RST_EN, dht_rst_n is low for 4 cycles per timeout.
- period_cfg=3000, enable=1, no ack -> starts every 3000 cycles. The second PUBLISH sets overrun=1; sample_ack clears valid and overrun.
- req held during BUSY plus a period tick coinciding with req -> exactly one follow-up read. Dropping enable during BUSY lets the current read publish and issues no further start.
- dht_error and dht_data_ready asserted in the same cycle -> treated as error, retry_cnt increments, no publish.
